udma_tx_stream: RTL and testbench

Parametrised uDMA TX-channel model feeding the UART TX path in the UART VIP. It holds a bench-loaded queue of characters and serves them over the uDMA req/gnt + valid/ready handshake, one character per request. It has configurable data width, queue depth, grant latency and a transfer counter, and supersedes single-shot character tasks in testbenches.

---
 rtl/udma_sim_pkg.sv | 15 +
 rtl/udma_sim_fifo.sv | 65 ++++++
 rtl/udma_tx_stream.sv | 109 ++++++++++
 tb/tb_udma_tx_stream.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/udma_sim_pkg.sv
// Shared types for the uDMA simulation models.
// udma_tx_state_e : TX channel FSM states.
// UDMA_DATA_WIDTH : default data bus width for the uDMA models.
package udma_sim_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        WAIT  = 2'd2,
        DATA  = 2'd3
    } udma_tx_state_e;

    localparam int UDMA_DATA_WIDTH = 32;

endpackage

// File: rtl/udma_sim_fifo.sv
// Synchronous FIFO with registered occupancy.
// There is no bypass, so a word pushed into an empty FIFO shows up at the
// head one cycle later.
// Ports:
//   sys_clk_i, sys_rst_i : clock, synchronous active-high reset
//   push_i, push_data_i  : write request and data (ignored when full)
//   pop_i                : read request (ignored when empty)
//   head_o               : word at the read pointer
//   level_o              : occupancy, 0..DEPTH
//   full_o, empty_o      : occupancy flags
module udma_sim_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
) (
    input  logic                     sys_clk_i,
    input  logic                     sys_rst_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         push_data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         head_o,
    output logic [$clog2(DEPTH):0]   level_o,
    output logic                     full_o,
    output logic                     empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LVL = DEPTH[AW:0];

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      level;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (level == FULL_LVL);
    assign empty_o = (level == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign head_o  = mem[rd_ptr];
    assign level_o = level;

    // Storage is not reset; only the pointers define what is valid.
    always_ff @(posedge sys_clk_i) begin
        if (do_push) mem[wr_ptr] <= push_data_i;
    end

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge sys_clk_i) begin
        if (sys_rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/udma_tx_stream.sv
// uDMA TX channel model: serves a bench-loaded character queue over the
// req/gnt + valid/ready handshake, one character per request.
// Ports:
//   sys_clk_i, sys_rst_i          : clock, synchronous active-high reset
//   enable_i                      : gate for accepting new requests
//   push_valid_i/push_data_i      : bench enqueue; push_ready_o = queue not full
//   data_tx_req_i/data_tx_gnt_o   : request in, one-cycle grant pulse out
//   data_tx_o/data_tx_valid_o     : character and valid, held until ready
//   data_tx_ready_i               : UART accepts the character
//   fifo_level_o, tx_count_o      : occupancy, completed transfers (wrapping)
//   overflow_o                    : sticky, push attempted while full
//   idle_o                        : FSM in IDLE with empty queue
module udma_tx_stream
    import udma_sim_pkg::*;
#(
    parameter int DATA_WIDTH  = UDMA_DATA_WIDTH,
    parameter int FIFO_DEPTH  = 8,
    parameter int GNT_LATENCY = 1,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                         sys_clk_i,
    input  logic                         sys_rst_i,
    input  logic                         enable_i,
    input  logic                         push_valid_i,
    input  logic [DATA_WIDTH-1:0]        push_data_i,
    output logic                         push_ready_o,
    input  logic                         data_tx_req_i,
    output logic                         data_tx_gnt_o,
    output logic [DATA_WIDTH-1:0]        data_tx_o,
    output logic                         data_tx_valid_o,
    input  logic                         data_tx_ready_i,
    output logic [$clog2(FIFO_DEPTH):0]  fifo_level_o,
    output logic [CNT_WIDTH-1:0]         tx_count_o,
    output logic                         overflow_o,
    output logic                         idle_o
);

    localparam logic [3:0] LAT_INIT = 4'(GNT_LATENCY - 1);

    udma_tx_state_e       state_q, state_d;
    logic [3:0]           lat_cnt_q;
    logic                 pop_q;
    logic [CNT_WIDTH-1:0] tx_count_q;
    logic                 overflow_q;
    logic [DATA_WIDTH-1:0] head;
    logic                 fifo_full;
    logic                 fifo_empty;

    // The accepting edge only registers the pop; queue, level and counter
    // move one edge later, which keeps every output a pure function of
    // registered state.
    udma_sim_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .sys_clk_i   (sys_clk_i),
        .sys_rst_i   (sys_rst_i),
        .push_i      (push_valid_i),
        .push_data_i (push_data_i),
        .pop_i       (pop_q),
        .head_o      (head),
        .level_o     (fifo_level_o),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

    always_ff @(posedge sys_clk_i) begin
        if (sys_rst_i) begin
            state_q    <= IDLE;
            lat_cnt_q  <= '0;
            pop_q      <= 1'b0;
            tx_count_q <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == GRANT)
                lat_cnt_q <= LAT_INIT;
            else if (state_q == WAIT && lat_cnt_q != '0)
                lat_cnt_q <= lat_cnt_q - 1'b1;
            pop_q <= (state_q == DATA) && data_tx_ready_i;
            if (pop_q) tx_count_q <= tx_count_q + 1'b1;
            if (push_valid_i && fifo_full) overflow_q <= 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            // Hold off while a pop is pending: the head still shows the
            // character just delivered.
            IDLE:    if (enable_i && data_tx_req_i && !fifo_empty && !pop_q)
                         state_d = GRANT;
            GRANT:   state_d = (GNT_LATENCY <= 1) ? DATA : WAIT;
            // Counter hits zero on this edge when it currently reads one.
            WAIT:    if (lat_cnt_q <= 4'd1) state_d = DATA;
            DATA:    if (data_tx_ready_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign data_tx_gnt_o   = (state_q == GRANT);
    assign data_tx_valid_o = (state_q == DATA);
    assign data_tx_o       = (state_q == DATA) ? head : '0;
    assign push_ready_o    = !fifo_full;
    assign tx_count_o      = tx_count_q;
    assign overflow_o      = overflow_q;
    assign idle_o          = (state_q == IDLE) && fifo_empty;

endmodule

// File: tb/tb_udma_tx_stream.sv
// Directed bench for udma_tx_stream. Instance 0: GNT_LATENCY=1, instance 1:
// GNT_LATENCY=4, both FIFO_DEPTH=4. Inputs change and outputs are sampled
// 1 time unit after each rising edge.
module tb_udma_tx_stream;

    logic        clk = 1'b0;
    logic        rst  [2];
    logic        en   [2];
    logic        pv   [2];
    logic [31:0] pd   [2];
    logic        pr   [2];
    logic        req  [2];
    logic        gnt  [2];
    logic [31:0] dtx  [2];
    logic        vld  [2];
    logic        rdy  [2];
    logic [2:0]  lvl  [2];
    logic [15:0] cnt  [2];
    logic        ovf  [2];
    logic        idl  [2];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        udma_tx_stream #(
            .DATA_WIDTH  (32),
            .FIFO_DEPTH  (4),
            .GNT_LATENCY ((g == 0) ? 1 : 4),
            .CNT_WIDTH   (16)
        ) u_dut (
            .sys_clk_i       (clk),
            .sys_rst_i       (rst[g]),
            .enable_i        (en[g]),
            .push_valid_i    (pv[g]),
            .push_data_i     (pd[g]),
            .push_ready_o    (pr[g]),
            .data_tx_req_i   (req[g]),
            .data_tx_gnt_o   (gnt[g]),
            .data_tx_o       (dtx[g]),
            .data_tx_valid_o (vld[g]),
            .data_tx_ready_i (rdy[g]),
            .fifo_level_o    (lvl[g]),
            .tx_count_o      (cnt[g]),
            .overflow_o      (ovf[g]),
            .idle_o          (idl[g])
        );
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int k, input logic [31:0] d);
        pv[k] = 1'b1;
        pd[k] = d;
        tick();
        pv[k] = 1'b0;
    endtask

    task automatic wait_vld(input int k);
        for (int i = 0; i < 20; i++) begin
            if (vld[k]) break;
            tick();
        end
        chk("wait_vld", {31'd0, vld[k]}, 32'd1);
    endtask

    initial begin
        logic [31:0] exp1 [3];
        exp1[0] = 32'h41; exp1[1] = 32'h42; exp1[2] = 32'h43;
        for (int k = 0; k < 2; k++) begin
            rst[k] = 1'b1; en[k] = 1'b1; pv[k] = 1'b0; pd[k] = '0;
            req[k] = 1'b0; rdy[k] = 1'b0;
        end
        tick(); tick();
        for (int k = 0; k < 2; k++) begin
            chk("rst_gnt",  {31'd0, gnt[k]}, 32'd0);
            chk("rst_vld",  {31'd0, vld[k]}, 32'd0);
            chk("rst_data", dtx[k], 32'd0);
            chk("rst_prdy", {31'd0, pr[k]},  32'd1);
            chk("rst_lvl",  {29'd0, lvl[k]}, 32'd0);
            chk("rst_cnt",  {16'd0, cnt[k]}, 32'd0);
            chk("rst_ovf",  {31'd0, ovf[k]}, 32'd0);
            chk("rst_idle", {31'd0, idl[k]}, 32'd1);
            rst[k] = 1'b0;
        end

        // Three characters back to back, latency 1: one per 4 cycles.
        push(0, 32'h41); push(0, 32'h42); push(0, 32'h43);
        chk("t1_lvl", {29'd0, lvl[0]}, 32'd3);
        req[0] = 1'b1; rdy[0] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick(); chk("t1_gnt", {31'd0, gnt[0]}, 32'd1);
            tick(); chk("t1_vld", {31'd0, vld[0]}, 32'd1);
                    chk("t1_data", dtx[0], exp1[i]);
                    chk("t1_gnt_lo", {31'd0, gnt[0]}, 32'd0);
            tick(); chk("t1_vld_lo", {31'd0, vld[0]}, 32'd0);
            tick(); chk("t1_lvl_dec", {29'd0, lvl[0]}, 32'(2 - i));
                    chk("t1_cnt", {16'd0, cnt[0]}, 32'(i + 1));
        end
        req[0] = 1'b0;
        chk("t1_idle", {31'd0, idl[0]}, 32'd1);

        // Overflow on a depth-4 queue.
        for (int i = 0; i < 5; i++) begin
            chk("t3_prdy", {31'd0, pr[0]}, (i < 4) ? 32'd1 : 32'd0);
            push(0, 32'(i + 1));
        end
        chk("t3_lvl",  {29'd0, lvl[0]}, 32'd4);
        chk("t3_ovf",  {31'd0, ovf[0]}, 32'd1);
        chk("t3_prdy_lo", {31'd0, pr[0]}, 32'd0);
        tick(); tick();
        chk("t3_ovf_sticky", {31'd0, ovf[0]}, 32'd1);
        chk("t3_head", {31'd0, gnt[0]}, 32'd0);
        rst[0] = 1'b1; tick(); rst[0] = 1'b0;
        chk("t3_ovf_clr", {31'd0, ovf[0]}, 32'd0);

        // Request against an empty queue, then push alongside the request.
        req[0] = 1'b1; rdy[0] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick(); chk("t4_nognt", {31'd0, gnt[0]}, 32'd0);
        end
        push(0, 32'h10);
        chk("t4_gnt_early", {31'd0, gnt[0]}, 32'd0);
        tick(); chk("t4_gnt", {31'd0, gnt[0]}, 32'd1);
        tick(); chk("t4_data", dtx[0], 32'h10);
        req[0] = 1'b0;
        tick(); tick();
        chk("t4_cnt", {16'd0, cnt[0]}, 32'd1);
        chk("t4_lvl", {29'd0, lvl[0]}, 32'd0);

        // Reset in the middle of DATA.
        push(0, 32'h77);
        req[0] = 1'b1; rdy[0] = 1'b0;
        wait_vld(0);
        chk("t6_data", dtx[0], 32'h77);
        req[0] = 1'b0; rst[0] = 1'b1;
        tick();
        rst[0] = 1'b0;
        chk("t6_vld", {31'd0, vld[0]}, 32'd0);
        chk("t6_lvl", {29'd0, lvl[0]}, 32'd0);
        chk("t6_cnt", {16'd0, cnt[0]}, 32'd0);
        push(0, 32'h99);
        req[0] = 1'b1; rdy[0] = 1'b1;
        wait_vld(0);
        chk("t6_data2", dtx[0], 32'h99);
        req[0] = 1'b0;
        tick(); tick();
        chk("t6_cnt2", {16'd0, cnt[0]}, 32'd1);
        chk("t6_lvl2", {29'd0, lvl[0]}, 32'd0);

        // Latency 4, ready held low for 5 valid cycles.
        push(1, 32'hA5);
        req[1] = 1'b1; rdy[1] = 1'b0;
        tick(); chk("t2_gnt", {31'd0, gnt[1]}, 32'd1);
        req[1] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick(); chk("t2_wait_vld", {31'd0, vld[1]}, 32'd0);
        end
        tick(); chk("t2_vld", {31'd0, vld[1]}, 32'd1);
        chk("t2_data", dtx[1], 32'hA5);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t2_hold_vld", {31'd0, vld[1]}, 32'd1);
            chk("t2_hold_data", dtx[1], 32'hA5);
        end
        rdy[1] = 1'b1;
        tick(); chk("t2_vld_lo", {31'd0, vld[1]}, 32'd0);
        tick();
        chk("t2_cnt", {16'd0, cnt[1]}, 32'd1);
        chk("t2_lvl", {29'd0, lvl[1]}, 32'd0);

        // Enable gating; dropping enable mid-transfer does not abort it.
        en[1] = 1'b0; req[1] = 1'b1;
        push(1, 32'h55);
        for (int i = 0; i < 4; i++) begin
            tick(); chk("t5_nognt", {31'd0, gnt[1]}, 32'd0);
        end
        en[1] = 1'b1;
        tick(); chk("t5_gnt", {31'd0, gnt[1]}, 32'd1);
        tick(); en[1] = 1'b0; req[1] = 1'b0;
        wait_vld(1);
        chk("t5_data", dtx[1], 32'h55);
        tick(); tick();
        chk("t5_cnt", {16'd0, cnt[1]}, 32'd2);
        chk("t5_idle", {31'd0, idl[1]}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
